// File: rtl/panel_buttons.sv
// Front-panel pushbutton conditioner: per-button synchronizer, debounce FSM,
// and press / release / long-press event generation.
module panel_buttons #(
    parameter int N_BTN      = 4,
    parameter int DEB_CYC    = 1000000,
    parameter int LONG_CYC   = 100000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic [N_BTN-1:0] btn_held
);

    localparam int CW = $clog2(LONG_CYC + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);
    // Long press counts from press acceptance, which is already DEB_CYC late.
    localparam logic [CW-1:0] HOLD_THR = CW'(LONG_CYC - DEB_CYC);
    localparam logic          RAW_REL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        LONG,
        RELEASE_WAIT
    } state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic          sync1;
        logic          sync2;
        logic          pressed;
        state_t        state;
        logic [CW-1:0] deb_cnt;
        logic [CW-1:0] hold_cnt;
        logic [CW-1:0] hold_inc;
        logic          hold_hit;
        logic          level_q;
        logic          press_q;
        logic          release_q;
        logic          long_q;
        logic          held_q;

        assign pressed  = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
        assign hold_inc = (hold_cnt < HOLD_THR) ? hold_cnt + 1'b1 : hold_cnt;
        // held_q doubles as "the interrupted state was LONG" inside RELEASE_WAIT.
        assign hold_hit = !held_q && (hold_inc == HOLD_THR);

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1     <= RAW_REL;
                sync2     <= RAW_REL;
                state     <= IDLE;
                deb_cnt   <= '0;
                hold_cnt  <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                held_q    <= 1'b0;
            end else begin
                sync1     <= btn_raw[i];
                sync2     <= sync1;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                case (state)
                    IDLE: begin
                        if (pressed) begin
                            state   <= PRESS_WAIT;
                            deb_cnt <= CNT_ONE;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!pressed) begin
                            state   <= IDLE;
                            deb_cnt <= '0;
                        end else if (deb_cnt == DEB_LAST) begin
                            state    <= PRESSED;
                            deb_cnt  <= '0;
                            hold_cnt <= '0;
                            level_q  <= 1'b1;
                            press_q  <= 1'b1;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                    PRESSED, LONG: begin
                        hold_cnt <= hold_inc;
                        if (!pressed) begin
                            state   <= RELEASE_WAIT;
                            deb_cnt <= CNT_ONE;
                        end else if (hold_hit) begin
                            state <= LONG;
                        end
                        if (hold_hit) begin
                            long_q <= 1'b1;
                            held_q <= 1'b1;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (pressed) begin
                            state    <= (held_q || hold_hit) ? LONG : PRESSED;
                            deb_cnt  <= '0;
                            hold_cnt <= hold_inc;
                            if (hold_hit) begin
                                long_q <= 1'b1;
                                held_q <= 1'b1;
                            end
                        end else if (deb_cnt == DEB_LAST) begin
                            state     <= IDLE;
                            deb_cnt   <= '0;
                            hold_cnt  <= '0;
                            level_q   <= 1'b0;
                            held_q    <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            // Hold time keeps running through a bounce so long-press timing is unaffected.
                            deb_cnt  <= deb_cnt + 1'b1;
                            hold_cnt <= hold_inc;
                            if (hold_hit) begin
                                long_q <= 1'b1;
                                held_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end
                endcase
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_long[i]    = long_q;
        assign btn_held[i]    = held_q;
    end

endmodule

// File: tb/tb_panel_buttons.sv
// Bench for panel_buttons: directed scenarios plus random button activity,
// checked every cycle against an event-level reference model.
module tb_panel_buttons;

  localparam int N = 4;
  localparam int DEB = 4;
  localparam int LNG = 16;
  localparam int THR = LNG - DEB;

  logic clk;
  logic rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_long;
  logic [N-1:0] btn_held;

  panel_buttons #(
    .N_BTN(N),
    .DEB_CYC(DEB),
    .LONG_CYC(LNG),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_long(btn_long),
    .btn_held(btn_held)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // reference model: level flips after DEB consecutive disagreeing synced samples
  logic [N-1:0] m_s1, m_s2, m_level, m_held, m_press, m_rel, m_long;
  int m_run[N];
  int m_age[N];
  logic [N-1:0] exp_q[$];

  task automatic model_step();
    logic [N-1:0] sync_p;
    m_press = '0;
    m_rel = '0;
    m_long = '0;
    if (rst) begin
      m_s1 = '1;
      m_s2 = '1;
      m_level = '0;
      m_held = '0;
      for (int b = 0; b < N; b++) begin
        m_run[b] = 0;
        m_age[b] = 0;
      end
    end else begin
      sync_p = ~m_s2;
      m_s2 = m_s1;
      m_s1 = btn_raw;
      for (int b = 0; b < N; b++) begin
        if (sync_p[b] != m_level[b]) begin
          m_run[b]++;
          if (m_run[b] == DEB) begin
            m_run[b] = 0;
            m_level[b] = ~m_level[b];
            if (m_level[b]) begin
              m_press[b] = 1'b1;
              m_age[b] = 0;
            end else begin
              m_rel[b] = 1'b1;
              m_held[b] = 1'b0;
            end
          end
        end else begin
          m_run[b] = 0;
        end
        if (m_level[b] && !m_press[b]) begin
          if (m_age[b] < THR) m_age[b]++;
          if (m_age[b] == THR && !m_held[b]) begin
            m_long[b] = 1'b1;
            m_held[b] = 1'b1;
          end
        end
      end
    end
    if (m_press != '0) exp_q.push_back(m_press);
  endtask

  // one clock: model advances on the edge, outputs compared 1 ns later
  task automatic tick();
    logic [N-1:0] got;
    @(posedge clk);
    model_step();
    #1;
    check("level", btn_level, m_level);
    check("press", btn_press, m_press);
    check("release", btn_release, m_rel);
    check("long", btn_long, m_long);
    check("held", btn_held, m_held);
    check("press_long_overlap", btn_press & btn_long, '0);
    check("press_release_overlap", btn_press & btn_release, '0);
    if (btn_press != '0) begin
      if (exp_q.size() == 0) begin
        check("press_unexpected", btn_press, '0);
      end else begin
        got = exp_q.pop_front();
        check("press_event", btn_press, got);
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // drivers
  task automatic press_btn(input int b);
    btn_raw[b] = 1'b0;
  endtask

  task automatic release_btn(input int b);
    btn_raw[b] = 1'b1;
  endtask

  int rem[N];

  initial begin
    rst = 1'b1;
    btn_raw = '1;
    run(3);
    check("reset_level", btn_level, '0);
    rst = 1'b0;
    run(3);

    // single press on button 0, visible after E0+5
    press_btn(0);
    run(6);
    check("b0_press_time", btn_press, 4'b0001);
    check("b0_level", btn_level, 4'b0001);
    run(4);
    release_btn(0);
    run(8);

    // 3-cycle glitch on button 1
    press_btn(1);
    run(3);
    release_btn(1);
    run(8);
    check("b1_glitch_level", btn_level, '0);

    // long press on button 2
    press_btn(2);
    run(18);
    check("b2_long_time", btn_long, 4'b0100);
    run(12);
    release_btn(2);
    run(6);
    check("b2_release_time", btn_release, 4'b0100);
    check("b2_held_clear", btn_held, '0);
    run(3);

    // 2-cycle bounce during a long-press count on button 2
    press_btn(2);
    run(10);
    release_btn(2);
    run(2);
    press_btn(2);
    run(6);
    check("bounce_long_time", btn_long, 4'b0100);
    run(3);
    release_btn(2);
    run(8);

    // reset during a held press on button 3
    press_btn(3);
    run(8);
    rst = 1'b1;
    run(2);
    check("rst_outputs", {btn_level, btn_press, btn_release, btn_long, btn_held}, '0);
    rst = 1'b0;
    run(6);
    check("post_rst_press", btn_press, 4'b1000);
    release_btn(3);
    run(8);

    // all buttons together
    btn_raw = '0;
    run(6);
    check("all_press", btn_press, 4'b1111);
    btn_raw = '1;
    run(8);

    // random activity with variable run lengths
    for (int b = 0; b < N; b++) rem[b] = $urandom_range(1, 30);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        rem[b]--;
        if (rem[b] <= 0) begin
          btn_raw[b] = ~btn_raw[b];
          rem[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(1, 30);
        end
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    btn_raw = '1;
    run(12);
    check("press_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
